// File: rtl/adc_pkg.sv
// Shared state type and default constants for the ADC frame reader.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    WRITE,
    INC
  } frame_state_t;

  localparam int unsigned ADC_SCLK_DIV   = 4;
  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam logic [15:0] ADC_CMD        = 16'h6000;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample timer: one-cycle registered tick every SAMPLE_PERIOD cycles while enabled.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_PERIOD = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  // Tick is registered, so it lands SAMPLE_PERIOD cycles after enable rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick <= w_wrap;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/adc_frame_reader.sv
// Periodic SPI mode-0 ADC read; writes each sample to memory, then pulses inc_adr.
module adc_frame_reader
  import adc_pkg::*;
#(
  parameter int unsigned           SCLK_DIV      = ADC_SCLK_DIV,
  parameter int unsigned           FRAME_BITS    = ADC_FRAME_BITS,
  parameter int unsigned           DATA_BITS     = ADC_DATA_BITS,
  parameter logic [FRAME_BITS-1:0] CMD           = ADC_CMD,
  parameter int unsigned           SAMPLE_PERIOD = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  output logic [DATA_BITS-1:0] sample,
  output logic                 we,
  output logic                 inc_adr,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned DW = $clog2(SCLK_DIV);
  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  frame_state_t            r_state, w_state;
  logic [DW-1:0]           r_div, w_div;
  logic [BW-1:0]           r_bit, w_bit;
  logic [FRAME_BITS-1:0]   r_tx, w_tx;
  logic [FRAME_BITS-1:0]   r_rx, w_rx;
  logic                    r_sclk, w_sclk;
  logic                    r_cs_n, w_cs_n;
  logic                    r_mosi, w_mosi;
  logic [DATA_BITS-1:0]    r_sample, w_sample;
  logic                    r_we, w_we;
  logic                    r_inc_adr, w_inc_adr;
  logic                    r_busy, w_busy;
  logic                    r_overrun, w_overrun;
  logic                    w_tick;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (w_tick)
  );

  always_comb begin
    w_state   = r_state;
    w_div     = r_div;
    w_bit     = r_bit;
    w_tx      = r_tx;
    w_rx      = r_rx;
    w_sclk    = r_sclk;
    w_cs_n    = r_cs_n;
    w_mosi    = r_mosi;
    w_sample  = r_sample;
    w_we      = 1'b0;
    w_inc_adr = 1'b0;
    w_busy    = r_busy;
    // Triggers arriving mid-frame are dropped and remembered.
    w_overrun = r_overrun | (w_tick && (r_state != IDLE));

    unique case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state = CS_SETUP;
          w_div   = '0;
          w_cs_n  = 1'b0;
          w_tx    = CMD;
          w_mosi  = CMD[FRAME_BITS-1];
          w_busy  = 1'b1;
        end
      end
      CS_SETUP: begin
        if (r_div == DIV_LAST) begin
          w_state = SHIFT;
          w_div   = '0;
          w_bit   = '0;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_div = r_div + 1'b1;
        end else begin
          w_div = '0;
          if (!r_sclk) begin
            // miso is stable through the low phase; capture it on the rising edge.
            w_sclk = 1'b1;
            w_rx   = {r_rx[FRAME_BITS-2:0], miso};
          end else begin
            w_sclk = 1'b0;
            if (r_bit == BIT_LAST) begin
              w_state = CS_HOLD;
              w_mosi  = 1'b0;
            end else begin
              w_bit  = r_bit + 1'b1;
              w_mosi = r_tx[FRAME_BITS-2];
              w_tx   = {r_tx[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
      end
      CS_HOLD: begin
        if (r_div == DIV_LAST) begin
          w_state  = WRITE;
          w_cs_n   = 1'b1;
          w_sample = r_rx[DATA_BITS-1:0];
          w_we     = 1'b1;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      WRITE: begin
        w_state   = INC;
        w_inc_adr = 1'b1;
      end
      INC: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_sample  <= '0;
      r_we      <= 1'b0;
      r_inc_adr <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_div     <= w_div;
      r_bit     <= w_bit;
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_sclk    <= w_sclk;
      r_cs_n    <= w_cs_n;
      r_mosi    <= w_mosi;
      r_sample  <= w_sample;
      r_we      <= w_we;
      r_inc_adr <= w_inc_adr;
      r_busy    <= w_busy;
      r_overrun <= w_overrun;
    end
  end

  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;
  assign sample  = r_sample;
  assign we      = r_we;
  assign inc_adr = r_inc_adr;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Bench for adc_frame_reader: ADC serial model, event recorder and timing/sample expectations.
module tb_adc_frame_reader;

  localparam int D      = 4;
  localparam int F      = 16;
  localparam int P      = 1000;
  localparam int P2     = 100;
  localparam int LAT_WE = 2 * D + 2 * F * D + 1;

  logic        clk = 1'b0;
  logic        rst, enable, miso;
  logic        sclk, cs_n, mosi, we, inc_adr, busy, overrun;
  logic [11:0] sample;
  logic        rst2, enable2, miso2;
  logic        sclk2, cs_n2, mosi2, we2, inc_adr2, busy2, overrun2;
  logic [11:0] sample2;

  always #5 clk = ~clk;

  adc_frame_reader #(.SAMPLE_PERIOD(P)) u_dut (
    .clk(clk), .reset(rst), .enable(enable), .miso(miso), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .sample(sample), .we(we), .inc_adr(inc_adr), .busy(busy), .overrun(overrun)
  );

  adc_frame_reader #(.SAMPLE_PERIOD(P2)) u_dut_ovr (
    .clk(clk), .reset(rst2), .enable(enable2), .miso(miso2), .sclk(sclk2), .cs_n(cs_n2),
    .mosi(mosi2), .sample(sample2), .we(we2), .inc_adr(inc_adr2), .busy(busy2),
    .overrun(overrun2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int fails = 0;

  int          cs_fall_q[$], we_t_q[$], inc_t_q[$], busy_rise_q[$], busy_fall_q[$];
  logic [11:0] we_s_q[$];
  int          rise_cnt = 0, bad_high = 0, high_len = 0, overlap_cnt = 0, dbl_cnt = 0;
  logic [15:0] mosi_bits = '0;
  logic        p_cs_n = 1'b1, p_sclk = 1'b0, p_we = 1'b0, p_inc = 1'b0, p_busy = 1'b0;
  logic [15:0] adc_q[$];
  logic [15:0] adc_word = '0;
  int          bidx = 0;

  int          we2_t_q[$], inc2_t_q[$], ovr2_rise_q[$];
  int          overlap2_cnt = 0;
  logic        p_ovr2 = 1'b0;

  // ADC model (shifts MSB first, next bit after each sclk fall) plus event recorder.
  always @(negedge clk) begin
    if (p_cs_n && !cs_n) begin
      cs_fall_q.push_back(cyc);
      if (adc_q.size() > 0) adc_word = adc_q.pop_front();
      else adc_word = '0;
      bidx = 15;
      miso = adc_word[15];
    end else if (p_sclk && !sclk && !cs_n && bidx > 0) begin
      bidx = bidx - 1;
      miso = adc_word[bidx[3:0]];
    end
    if (!p_sclk && sclk) begin
      rise_cnt++;
      mosi_bits = {mosi_bits[14:0], mosi};
      high_len = 1;
    end else if (sclk) begin
      high_len++;
    end
    if (p_sclk && !sclk && high_len != D) bad_high++;
    if (we) begin
      we_t_q.push_back(cyc);
      we_s_q.push_back(sample);
    end
    if (inc_adr) inc_t_q.push_back(cyc);
    if (we && inc_adr) overlap_cnt++;
    if ((we && p_we) || (inc_adr && p_inc)) dbl_cnt++;
    if (!p_busy && busy) busy_rise_q.push_back(cyc);
    if (p_busy && !busy) busy_fall_q.push_back(cyc);
    p_cs_n = cs_n;
    p_sclk = sclk;
    p_we   = we;
    p_inc  = inc_adr;
    p_busy = busy;
    if (we2) we2_t_q.push_back(cyc);
    if (inc_adr2) inc2_t_q.push_back(cyc);
    if (we2 && inc_adr2) overlap2_cnt++;
    if (!p_ovr2 && overrun2) ovr2_rise_q.push_back(cyc);
    p_ovr2 = overrun2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_records();
    cs_fall_q.delete(); we_t_q.delete(); inc_t_q.delete(); we_s_q.delete();
    busy_rise_q.delete(); busy_fall_q.delete();
    rise_cnt = 0; bad_high = 0; overlap_cnt = 0; dbl_cnt = 0; mosi_bits = '0;
    we2_t_q.delete(); inc2_t_q.delete(); ovr2_rise_q.delete(); overlap2_cnt = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One completed frame: tick at t, sample s expected.
  task automatic check_one_frame(input string tag, input int t, input logic [11:0] s);
    check({tag, "_cs_n"}, 32'(cs_fall_q.size()), 32'd1);
    if (cs_fall_q.size() >= 1) check({tag, "_cs_t"}, 32'(cs_fall_q[0]), 32'(t + 1));
    check({tag, "_we_n"}, 32'(we_t_q.size()), 32'd1);
    if (we_t_q.size() >= 1) begin
      check({tag, "_we_t"}, 32'(we_t_q[0]), 32'(t + LAT_WE));
      check({tag, "_smp"}, 32'(we_s_q[0]), 32'(s));
    end
    check({tag, "_inc_n"}, 32'(inc_t_q.size()), 32'd1);
    if (inc_t_q.size() >= 1) check({tag, "_inc_t"}, 32'(inc_t_q[0]), 32'(t + LAT_WE + 1));
  endtask

  int          t_tick, t2;
  logic [15:0] w;
  logic [11:0] exp_s[5];
  logic [11:0] s_cur;

  initial begin
    rst = 1'b1; rst2 = 1'b1; enable = 1'b0; enable2 = 1'b0; miso = 1'b0; miso2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_inc", 32'(inc_adr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0; rst2 = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame returning 12'hA5C.
    w = {4'($urandom), 12'hA5C};
    adc_q.push_back(w);
    @(posedge clk); clear_records();
    @(negedge clk); enable = 1'b1; t_tick = cyc + P;
    wait_until(t_tick + LAT_WE + 4);
    check_one_frame("single", t_tick, 12'hA5C);
    check("single_rises", 32'(rise_cnt), 32'd16);
    check("single_high", 32'(bad_high), 32'd0);
    check("single_mosi", 32'(mosi_bits), 32'h6000);
    if (busy_rise_q.size() >= 1) check("busy_rise", 32'(busy_rise_q[0]), 32'(t_tick + 1));
    else check("busy_rise_n", 32'(busy_rise_q.size()), 32'd1);
    if (busy_fall_q.size() >= 1) check("busy_fall", 32'(busy_fall_q[0]), 32'(t_tick + LAT_WE + 2));
    else check("busy_fall_n", 32'(busy_fall_q.size()), 32'd1);
    check("held_sample", 32'(sample), 32'h0A5C);

    // Continuous run: five random samples.
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      adc_q.push_back(w);
      exp_s[i] = w[11:0];
    end
    @(posedge clk); clear_records();
    wait_until(t_tick + 5 * P + LAT_WE + 4);
    check("cont_we_n", 32'(we_t_q.size()), 32'd5);
    check("cont_inc_n", 32'(inc_t_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (we_t_q.size() > i) begin
        check("cont_we_t", 32'(we_t_q[i]), 32'(t_tick + (i + 1) * P + LAT_WE));
        check("cont_smp", 32'(we_s_q[i]), 32'(exp_s[i]));
      end
      if (inc_t_q.size() > i) check("cont_inc_t", 32'(inc_t_q[i]), 32'(t_tick + (i + 1) * P + LAT_WE + 1));
    end
    check("cont_ovr", 32'(overrun), 32'd0);
    check("cont_overlap", 32'(overlap_cnt), 32'd0);
    check("cont_double", 32'(dbl_cnt), 32'd0);
    check("cont_rises", 32'(rise_cnt), 32'd80);
    t_tick = t_tick + 5 * P;

    // Enable drops mid-frame: frame completes, then silence.
    t_tick = t_tick + P;
    s_cur = 12'($urandom_range(1, 4095));
    adc_q.push_back({4'($urandom), s_cur});
    @(posedge clk); clear_records();
    wait_until(t_tick + 50); enable = 1'b0;
    wait_until(t_tick + 50 + 3000);
    check_one_frame("endrop", t_tick, s_cur);

    // Enable restart: cs_n falls SAMPLE_PERIOD+1 cycles after enable.
    s_cur = 12'($urandom_range(1, 4095));
    adc_q.push_back({4'($urandom), s_cur});
    @(posedge clk); clear_records();
    @(negedge clk); enable = 1'b1; t_tick = cyc + P;
    wait_until(t_tick + LAT_WE + 4);
    check_one_frame("restart", t_tick, s_cur);

    // Reset mid-frame.
    t_tick = t_tick + P;
    adc_q.push_back(16'($urandom));
    wait_until(t_tick + 60);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sample", 32'(sample), 32'd0);
    check("mid_rst_we", 32'(we), 32'd0);
    @(posedge clk); clear_records();
    repeat (4) @(negedge clk);
    s_cur = 12'($urandom_range(1, 4095));
    adc_q.push_back({4'($urandom), s_cur});
    rst = 1'b0; t_tick = cyc + P;
    wait_until(t_tick + LAT_WE + 4);
    check_one_frame("post_rst", t_tick, s_cur);

    // Overrun on the short-period instance.
    @(posedge clk); clear_records();
    @(negedge clk); enable2 = 1'b1; t2 = cyc + P2;
    wait_until(t2 + 4 * P2 + LAT_WE + 4);
    check("ovr_rise_n", 32'(ovr2_rise_q.size()), 32'd1);
    if (ovr2_rise_q.size() >= 1) check("ovr_rise_t", 32'(ovr2_rise_q[0]), 32'(t2 + P2 + 1));
    check("ovr_sticky", 32'(overrun2), 32'd1);
    check("ovr_we_n", 32'(we2_t_q.size()), 32'd3);
    check("ovr_inc_n", 32'(inc2_t_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (we2_t_q.size() > i) check("ovr_we_t", 32'(we2_t_q[i]), 32'(t2 + 2 * P2 * i + LAT_WE));
      if (inc2_t_q.size() > i) check("ovr_inc_t", 32'(inc2_t_q[i]), 32'(t2 + 2 * P2 * i + LAT_WE + 1));
    end
    check("ovr_sample", 32'(sample2), 32'h0FFF);
    check("ovr_overlap", 32'(overlap2_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
